// File: rtl/axi_lite_pkg.sv
// Shared constants, state encodings and helpers for the AXI4-Lite SRAM responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    // Galois form, taps 16,14,13,11 (maximal length).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ 16'hB400;
        end
        return nxt;
    endfunction

    // 4 + n does not always fit the 4-bit latency counter, so it saturates.
    function automatic logic [3:0] rand_lat_load(input logic [3:0] n);
        logic [4:0] sum;
        sum = 5'd4 + {1'b0, n};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

endpackage

// File: rtl/axi_lat_ctr.sv
// 4-bit load/decrement latency counter with a zero flag.
module axi_lat_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-organised SRAM with per-channel latency.
// Define AXI_SLV_RAND_DELAY_EN for LFSR-driven latency and ready throttling.
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic       ready_gate;
    logic [3:0] rd_load_val;
    logic [3:0] wr_load_val;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign ready_gate  = lfsr[8];
    assign rd_load_val = rand_lat_load(lfsr[3:0]);
    assign wr_load_val = rand_lat_load(lfsr[7:4]);
`else
    assign ready_gate  = 1'b0;
    assign rd_load_val = 4'(RD_LAT - 1);
    assign wr_load_val = 4'(WR_LAT - 1);
`endif

    // ---------------- write path ----------------
    wr_state_e   w_state, w_next;
    logic        aw_captured, w_captured;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs;
    logic        w_load, w_dec, w_commit, w_zero;

    assign awready = (w_state == W_IDLE) && !aw_captured && !ready_gate;
    assign wready  = (w_state == W_IDLE) && !w_captured && !ready_gate;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        w_next   = w_state;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if ((aw_captured || aw_hs) && (w_captured || w_hs)) begin
                    w_load = 1'b1;
                    w_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_zero) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Capture flags clear once the pair moves on; the state itself keeps the readies low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            bresp       <= RESP_OKAY;
        end else begin
            if (w_load) begin
                aw_captured <= 1'b0;
                w_captured  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_captured <= 1'b1;
                end
                if (w_hs) begin
                    w_captured <= 1'b1;
                end
            end
            if (w_commit) begin
                bresp <= in_range(awaddr_q) ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_q <= awaddr;
        end
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    axi_lat_ctr u_wr_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (wr_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // A reset landing on the commit edge must abort the write, hence the rst_n term.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && in_range(awaddr_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[word_idx(awaddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_e   r_state, r_next;
    logic [31:0] araddr_q;
    logic        ar_hs;
    logic        r_load, r_dec, r_sample, r_zero;

    assign arready = (r_state == R_IDLE) && !ready_gate;
    assign rvalid  = (r_state == R_RESP);
    assign ar_hs   = arvalid && arready;

    always_comb begin
        r_next   = r_state;
        r_load   = 1'b0;
        r_dec    = 1'b0;
        r_sample = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_load = 1'b1;
                    r_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_zero) begin
                    r_sample = 1'b1;
                    r_next   = R_RESP;
                end else begin
                    r_dec = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            araddr_q <= araddr;
        end
    end

    axi_lat_ctr u_rd_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (r_load),
        .load_val (rd_load_val),
        .dec      (r_dec),
        .zero     (r_zero)
    );

    // Non-blocking sampling returns the pre-commit word when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 32'd0;
            rresp <= RESP_OKAY;
        end else if (r_sample) begin
            if (in_range(araddr_q)) begin
                rdata <= mem[word_idx(araddr_q)];
                rresp <= RESP_OKAY;
            end else begin
                rdata <= 32'd0;
                rresp <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed self-checking bench for axi_lite_sram_slave (default latency build).
module tb_axi_lite_sram_slave;

    logic        clk;
    logic        rst_n;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic        wready, wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_sram_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awready (awready),
        .awvalid (awvalid),
        .awaddr  (awaddr),
        .wready  (wready),
        .wvalid  (wvalid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bready  (bready),
        .bvalid  (bvalid),
        .bresp   (bresp),
        .arready (arready),
        .arvalid (arvalid),
        .araddr  (araddr),
        .rready  (rready),
        .rvalid  (rvalid),
        .rresp   (rresp),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Callers start 1ns after a rising edge; lat counts edges from the handshake edge inclusive.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1; n = 0;
        while (!bvalid && n < 50) begin
            @(posedge clk); #1;
            lat++; n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("[TB] FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        araddr = a; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 1; n = 0;
        while (!rvalid && n < 50) begin
            @(posedge clk); #1;
            lat++; n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("[TB] FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (awready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_awready: got %b required 1", awready); end
        n_checks++; if (wready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wready: got %b required 1", wready); end
        n_checks++; if (arready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_arready: got %b required 1", arready); end
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bvalid: got %b required 0", bvalid); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b required 0", rvalid); end
        n_checks++; if (bresp !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_bresp: got %b required 00", bresp); end
        n_checks++; if (rresp !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rresp: got %b required 00", rresp); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h required 0", rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, resp, lat);
        n_checks++; if (lat != 2) begin n_fail++; $display("[TB] FAIL aligned_wr_latency: got %0d required 2", lat); end
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("[TB] FAIL aligned_bresp: got %b required 00", resp); end
        do_read(32'h8000_0010, d, resp, lat);
        n_checks++; if (lat != 2) begin n_fail++; $display("[TB] FAIL aligned_rd_latency: got %0d required 2", lat); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL aligned_rdata: got %h required deadbeef", d); end
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("[TB] FAIL aligned_rresp: got %b required 00", resp); end
    endtask

    task automatic test_partial_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        do_write(32'h8000_0020, 32'h11223344, 4'hF, resp, lat);
        do_write(32'h8000_0020, 32'hAABBCCDD, 4'b0110, resp, lat);
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("[TB] FAIL partial_bresp: got %b required 00", resp); end
        do_read(32'h8000_0020, d, resp, lat);
        n_checks++; if (d !== 32'h11BBCC44) begin n_fail++; $display("[TB] FAIL partial_rdata: got %h required 11bbcc44", d); end
        // addr[1:0] is ignored: a byte-offset address hits the same word
        do_read(32'h8000_0023, d, resp, lat);
        n_checks++; if (d !== 32'h11BBCC44) begin n_fail++; $display("[TB] FAIL unaligned_rdata: got %h required 11bbcc44", d); end
    endtask

    task automatic test_split_aw_w();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        awaddr = 32'h8000_0030; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            n_checks++;
            if (awready !== 1'b0) begin n_fail++; $display("[TB] FAIL split_awready_c%0d: got %b required 0", cyc, awready); end
            n_checks++;
            if (bvalid !== (cyc == 5)) begin n_fail++; $display("[TB] FAIL split_bvalid_c%0d: got %b required %b", cyc, bvalid, cyc == 5); end
            if (cyc == 1) awvalid = 1'b0;
            if (cyc == 3) wvalid = 1'b1;
            if (cyc == 4) wvalid = 1'b0;
        end
        n_checks++; if (bresp !== 2'b00) begin n_fail++; $display("[TB] FAIL split_bresp: got %b required 00", bresp); end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_checks++; if (awready !== 1'b1) begin n_fail++; $display("[TB] FAIL split_awready_after_b: got %b required 1", awready); end
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL split_bvalid_after_b: got %b required 0", bvalid); end
        do_read(32'h8000_0030, d, resp, lat);
        n_checks++; if (d !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL split_rdata: got %h required cafef00d", d); end
    endtask

    task automatic test_backpressure();
        int n;
        araddr = 32'h8000_0030; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            n_checks++;
            if (arready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_arready_wait: got %b required 0", arready); end
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 50) begin n_fail++; $display("[TB] FAIL bp_timeout: rvalid=%b required 1", rvalid); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_rvalid_%0d: got %b required 1", i, rvalid); end
            n_checks++;
            if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL bp_rdata_%0d: got %h required cafef00d", i, rdata); end
            n_checks++;
            if (arready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_arready_%0d: got %b required 0", i, arready); end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_rvalid_after: got %b required 0", rvalid); end
        n_checks++; if (arready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_arready_after: got %b required 1", arready); end
    endtask

    task automatic test_decode_error();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        do_read(32'h7FFF_FFFC, d, resp, lat);
        n_checks++; if (resp !== 2'b11) begin n_fail++; $display("[TB] FAIL decerr_rresp_low: got %b required 11", resp); end
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL decerr_rdata_low: got %h required 0", d); end
        do_write(32'h8000_0000, 32'h01234567, 4'hF, resp, lat);
        do_write(32'h8000_1000, 32'hFFFFFFFF, 4'hF, resp, lat);
        n_checks++; if (resp !== 2'b11) begin n_fail++; $display("[TB] FAIL decerr_bresp_high: got %b required 11", resp); end
        do_read(32'h8000_0000, d, resp, lat);
        n_checks++; if (d !== 32'h01234567) begin n_fail++; $display("[TB] FAIL decerr_word0: got %h required 01234567", d); end
        do_read(32'h8000_1000, d, resp, lat);
        n_checks++; if (resp !== 2'b11) begin n_fail++; $display("[TB] FAIL decerr_rresp_high: got %b required 11", resp); end
        do_write(32'h8000_0FFC, 32'h0BADF00D, 4'hF, resp, lat);
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("[TB] FAIL last_word_bresp: got %b required 00", resp); end
        do_read(32'h8000_0FFC, d, resp, lat);
        n_checks++; if (d !== 32'h0BADF00D) begin n_fail++; $display("[TB] FAIL last_word_rdata: got %h required 0badf00d", d); end
    endtask

    task automatic test_same_cycle_rw();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        do_write(32'h8000_0060, 32'hAAAA0001, 4'hF, resp, lat);
        araddr = 32'h8000_0060; arvalid = 1'b1;
        awaddr = 32'h8000_0060; wdata = 32'hBBBB0002; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL samecyc_rvalid: got %b required 1", rvalid); end
        n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL samecyc_bvalid: got %b required 1", bvalid); end
        n_checks++; if (rdata !== 32'hAAAA0001) begin n_fail++; $display("[TB] FAIL samecyc_old_data: got %h required aaaa0001", rdata); end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0060, d, resp, lat);
        n_checks++; if (d !== 32'hBBBB0002) begin n_fail++; $display("[TB] FAIL samecyc_new_data: got %h required bbbb0002", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        do_write(32'h8000_0040, 32'h55AA55AA, 4'hF, resp, lat);
        awaddr = 32'h8000_0040; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_bvalid: got %b required 0", bvalid); end
        n_checks++; if (awready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_awready: got %b required 1", awready); end
        n_checks++; if (wready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_wready: got %b required 1", wready); end
        n_checks++; if (arready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_arready: got %b required 1", arready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_bvalid_after: got %b required 0", bvalid); end
        do_read(32'h8000_0040, d, resp, lat);
        n_checks++; if (d !== 32'h55AA55AA) begin n_fail++; $display("[TB] FAIL midrst_word: got %h required 55aa55aa", d); end
    endtask

    initial begin
        $display("[TB] starting axi_lite_sram_slave bench");
        test_reset();
        test_aligned();
        test_partial_strobe();
        test_split_aw_w();
        test_backpressure();
        test_decode_error();
        test_same_cycle_rw();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder (slave) that backs the LSU's master port with a word-organised SRAM model.
- Sits at the far end of the LSU AW/W/B/AR/R channels.
- Fixed, per-channel programmable latency, so the LSU's handshake and two-beat misaligned sequences can be exercised.
- Read and write paths are independent FSMs sharing one memory array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- RD_LAT, 1: cycles from AR handshake to rvalid assertion; range 1..15.
- WR_LAT, 1: cycles from both AW and W being captured to bvalid assertion; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- awready  out  1  write address ready
- awvalid  in  1  write address valid
- awaddr  in  32  write byte address
- wready  out  1  write data ready
- wvalid  in  1  write data valid
- wdata  in  32  write data, already lane-aligned by the master
- wstrb  in  4  byte enables
- bready  in  1  response ready
- bvalid  out  1  response valid
- bresp  out  2  response code
- arready  out  1  read address ready
- arvalid  in  1  read address valid
- araddr  in  32  read byte address
- rready  in  1  read data ready
- rvalid  out  1  read data valid
- rresp  out  2  read response code
- rdata  out  32  read data

Behaviour:
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
- Memory contents are not reset.
- Reset asserted mid-transaction aborts the transaction:
  - The pending write is not committed unless it already committed.
  - All outputs return to reset values on the next clock edge.
- Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored: the full word is always returned or written under wstrb.
- Out of range when addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS:
  - Read returns rresp=2'b11 (DECERR) with rdata=0.
  - Write gets bresp=2'b11 and the memory is unchanged.
  - In range: OKAY (2'b00).
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: AW and W are accepted independently. Handshake on awvalid&awready captures the address and drops awready. Handshake on wvalid&wready captures data and strobe and drops wready. Both in the same cycle is legal.
  - Once both are captured, load the counter with WR_LAT-1 and go to W_WAIT.
  - W_WAIT: decrement the counter. At 0, commit the bytes whose wstrb bit is 1, assert bvalid with bresp, and go to W_RESP.
  - W_RESP: hold bvalid/bresp stable until bready. On bvalid&bready: bvalid=0, awready=wready=1, go to W_IDLE.
  - Next AW is accepted no earlier than the cycle after the B handshake.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: on arvalid&arready, capture the address, arready=0, load the counter with RD_LAT-1, go to R_WAIT.
  - R_WAIT: at counter 0, sample the memory into rdata, set rresp, rvalid=1, go to R_RESP.
  - R_RESP: hold rvalid/rdata stable until rready. On handshake: rvalid=0, arready=1, go to R_IDLE.
- Minimum latency is 2 cycles from AR handshake to rvalid when RD_LAT=1 (capture edge, then sample edge); the same applies to AW/W-to-bvalid.
- Same-cycle read sample and write commit to one word: the read returns the old data.
- A back-to-back second beat (LSU address+4) needs no special handling; each beat is an independent transaction.
- No outstanding-transaction queue: at most one read and one write in flight.

Optional Feature:
- AXI_SLV_RAND_DELAY_EN defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, advances every cycle, reset to seed) replaces the fixed latency loads. Counter load = 4 + lfsr[3:0] for reads and 4 + lfsr[7:4] for writes.
  - awready/wready/arready in IDLE are additionally gated low when lfsr[8]=1, to stress master valid-hold.
- Not defined: fixed RD_LAT/WR_LAT, and the readies are exactly as above.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11.
  - Read and write state enums (2 bits).
  - The LFSR seed constant.
- One sub-module, axi_lat_ctr: 4-bit load/decrement counter with a zero flag. One instance serves the read path and one the write path.

Test Plan:
- Aligned write then read:
  - Write 32'hDEADBEEF to 0x8000_0010 with wstrb=4'hF. Expect bvalid 2 cycles after the joint AW/W handshake with bresp=0.
  - Then read 0x8000_0010. Expect rdata=32'hDEADBEEF and rresp=0.
- Partial strobe: preload 0x8000_0020=32'h11223344, write wdata=32'hAABBCCDD with wstrb=4'b0110. A subsequent read returns 32'h11BBCC44.
- Split AW/W: assert awvalid at cycle 0 and wvalid at cycle 3. No bvalid before cycle 5. awready stays low from cycle 1 until the B handshake.
- Backpressure: hold rready=0 for 5 cycles after rvalid. rvalid and rdata stay stable; arready=0 throughout; arready=1 the cycle after the handshake.
- Decode error: read 0x7FFF_FFFC gives rresp=2'b11 and rdata=0. Write to 0x8000_1000 (DEPTH 1024) gives bresp=2'b11, and a re-read of word 0 is unchanged.
- Reset mid-write: drop rst_n during W_WAIT. The next cycle shows bvalid=0 and all readies=1, and the target word is unchanged.
